// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: FSM states, default NOP, index-width helper.
package imem_pkg;

    typedef enum logic {
        IMEM_LOAD = 1'b0,
        IMEM_RUN  = 1'b1
    } imem_state_e;

    // MIPS NOP is sll $0,$0,0, which encodes as all zeros.
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    function automatic int imem_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_ram_1r1w.sv
// DEPTH x DATA_W simple dual-port array: synchronous write, registered read with enable.
module imem_ram_1r1w #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[raddr_sel(waddr_i)] <= wdata_i;
        end
    end

    // Output register holds its value between reads so the fetched word stays stable.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

    function automatic logic [IDX_W-1:0] raddr_sel(input logic [IDX_W-1:0] a);
        return a;
    endfunction

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: boot-time load handshake, then 1-cycle fetch with NOP masking.
// Optional IMEM_ALIGN_CHECK_EN adds a fetch_fault output for misaligned fetch addresses.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(MIPS_NOP),
    localparam int               IDX_W    = imem_idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_done,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic [IDX_W:0]    loaded_count
`ifdef IMEM_ALIGN_CHECK_EN
    ,
    output logic              fetch_fault
`endif
);

    imem_state_e       state_q, state_d;
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]    count_q, count_d;
    logic              valid_q;
    logic              nop_q, nop_d;
    logic              wr_en;
    logic              fetch_accept;
    logic [IDX_W-1:0]  fetch_idx;
    logic              out_of_range;
    logic              past_loaded;
    logic              misaligned;
    logic [DATA_W-1:0] ram_rdata;

    assign fetch_idx    = fetch_addr[IDX_W+1:2];
    assign out_of_range = |fetch_addr[31:IDX_W+2];
    assign past_loaded  = ({1'b0, fetch_idx} >= count_q);

`ifdef IMEM_ALIGN_CHECK_EN
    assign misaligned = |fetch_addr[1:0];
`else
    logic unused_addr_bits;
    assign misaligned       = 1'b0;
    assign unused_addr_bits = ^fetch_addr[1:0];
`endif

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        nop_d        = nop_q;
        load_ready   = (state_q == IMEM_LOAD);
        load_done    = (state_q == IMEM_RUN);
        wr_en        = 1'b0;
        fetch_accept = 1'b0;

        case (state_q)
            IMEM_LOAD: begin
                if (load_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                    // Writing the last slot ends the load even without load_last.
                    if (load_last || (wr_ptr_q == IDX_W'(DEPTH - 1))) begin
                        state_d = IMEM_RUN;
                    end
                end
            end
            IMEM_RUN: begin
                if (load_start) begin
                    state_d  = IMEM_LOAD;
                    wr_ptr_d = '0;
                    count_d  = '0;
                end else begin
                    fetch_accept = fetch_req;
                end
            end
            default: state_d = IMEM_LOAD;
        endcase

        if (fetch_accept) begin
            nop_d = out_of_range | past_loaded | misaligned;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IMEM_LOAD;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            nop_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= fetch_accept;
            nop_q    <= nop_d;
        end
    end

`ifdef IMEM_ALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fetch_accept & misaligned;
        end
    end

    assign fetch_fault = fault_q;
`endif

    imem_ram_1r1w #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rst_i   (reset),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (load_data),
        .re_i    (fetch_accept),
        .raddr_i (fetch_idx),
        .rdata_o (ram_rdata)
    );

    assign fetch_valid  = valid_q;
    assign fetch_data   = nop_q ? NOP_WORD : ram_rdata;
    assign loaded_count = count_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: directed vector table, corner sequences, random fetches vs. array model.
module tb_imem_loadable;

    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 64;
    localparam int          IDX_W  = 6;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start;
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_done;
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic [IDX_W:0]    loaded_count;
`ifdef IMEM_ALIGN_CHECK_EN
    logic              fetch_fault;
`endif

    imem_loadable #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_done    (load_done),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_valid  (fetch_valid),
        .fetch_data   (fetch_data),
        .loaded_count (loaded_count)
`ifdef IMEM_ALIGN_CHECK_EN
        ,
        .fetch_fault  (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: what the program array should look like from the outside.
    logic [31:0] m_mem [DEPTH];
    int          m_count;
    bit          m_run;
    int          total;
    int          bad;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        int idx;
`ifdef IMEM_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) return NOP;
`endif
        if (a >= 32'(DEPTH * 4)) return NOP;
        idx = int'(a >> 2);
        if (idx >= m_count) return NOP;
        return m_mem[idx];
    endfunction

    task automatic load_word(input logic [31:0] d, input bit last);
        chk("load_ready", 64'(load_ready), 64'(!m_run));
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        @(posedge clk); #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        if (!m_run) begin
            m_mem[m_count] = d;
            m_count++;
            if (last || m_count == DEPTH) m_run = 1'b1;
        end
        chk("loaded_count", 64'(loaded_count), 64'(m_count));
    endtask

    task automatic fetch_one(input logic [31:0] a);
        logic [31:0] e;
        e = exp_word(a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        $display("fetch addr=%08h data=%08h valid=%0b", a, fetch_data, fetch_valid);
        chk("fetch_valid", 64'(fetch_valid), 64'(1));
        chk("fetch_data", 64'(fetch_data), 64'(e));
`ifdef IMEM_ALIGN_CHECK_EN
        chk("fetch_fault", 64'(fetch_fault), 64'(a[1:0] != 2'b00));
`endif
    endtask

    task automatic pulse_load_start();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        if (m_run) begin
            m_run   = 1'b0;
            m_count = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        m_run   = 1'b0;
        m_count = 0;
    endtask

    task automatic rand_fetch(input int n);
        logic [31:0] a;
        logic [31:0] e;
        logic [31:0] exp_last;
        bit          r;
        exp_last = '0;
        for (int i = 0; i < n; i++) begin
            r = (i == 0) || ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) begin
                a = $urandom;
            end else begin
                a = 32'($urandom_range(0, DEPTH + 7)) << 2;
                if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            end
            e = exp_word(a);
            fetch_req  = r;
            fetch_addr = a;
            @(posedge clk); #1;
            if (r) exp_last = e;
            chk("rand_valid", 64'(fetch_valid), 64'(r));
            chk("rand_data", 64'(fetch_data), 64'(exp_last));
`ifdef IMEM_ALIGN_CHECK_EN
            chk("rand_fault", 64'(fetch_fault), 64'(r && (a[1:0] != 2'b00)));
`endif
        end
        fetch_req = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        total      = 0;
        bad        = 0;
        m_count    = 0;
        m_run      = 1'b0;
        reset      = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_load_ready", 64'(load_ready), 64'(1));
        chk("rst_load_done", 64'(load_done), 64'(0));
        chk("rst_fetch_valid", 64'(fetch_valid), 64'(0));
        chk("rst_fetch_data", 64'(fetch_data), 64'(0));
        chk("rst_loaded_count", 64'(loaded_count), 64'(0));

        // 18-word program, stalled for 3 cycles after word 5 with a fetch attempt during LOAD.
        for (int i = 0; i < 18; i++) begin
            w = (i == 5) ? 32'h0064_2824 : (32'hA500_0000 + 32'(i));
            if (i == 5) begin
                for (int g = 0; g < 3; g++) begin
                    fetch_req  = (g == 1);
                    fetch_addr = 32'h0;
                    @(posedge clk); #1;
                    fetch_req = 1'b0;
                    chk("gap_count", 64'(loaded_count), 64'(5));
                    chk("gap_fetch_valid", 64'(fetch_valid), 64'(0));
                end
            end
            load_word(w, i == 17);
        end
        chk("prog_done", 64'(load_done), 64'(1));
        chk("prog_ready", 64'(load_ready), 64'(0));
        chk("prog_count", 64'(loaded_count), 64'(18));

        vt[0] = '{32'h0000_0014, 32'h0064_2824};
        vt[1] = '{32'h0000_0000, 32'hA500_0000};
        vt[2] = '{32'h0000_0044, 32'hA500_0011};
        vt[3] = '{32'h0000_0048, NOP};
        vt[4] = '{32'h0000_0400, NOP};
        vt[5] = '{32'h0000_00FC, NOP};
        vt[6] = '{32'h0000_0100, NOP};
        vt[7] = '{32'h0000_0008, 32'hA500_0002};
        for (int i = 0; i < 8; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = vt[i].addr;
            @(posedge clk); #1;
            fetch_req = 1'b0;
            $display("vec %0d addr=%08h data=%08h", i, vt[i].addr, fetch_data);
            chk("vec_valid", 64'(fetch_valid), 64'(1));
            chk("vec_data", 64'(fetch_data), 64'(vt[i].exp_data));
        end

        rand_fetch(120);

        // load_start together with fetch_req: fetch dropped, back to LOAD.
        load_start = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        @(posedge clk); #1;
        load_start = 1'b0;
        fetch_req  = 1'b0;
        m_run   = 1'b0;
        m_count = 0;
        chk("ls_fetch_valid", 64'(fetch_valid), 64'(0));
        chk("ls_load_ready", 64'(load_ready), 64'(1));
        chk("ls_count", 64'(loaded_count), 64'(0));

        // Full array with load_last never set, then an extra word that must be ignored.
        for (int i = 0; i < DEPTH; i++) load_word($urandom, 1'b0);
        chk("full_ready", 64'(load_ready), 64'(0));
        chk("full_done", 64'(load_done), 64'(1));
        load_word(32'hDEAD_BEEF, 1'b1);
        fetch_one(32'h0000_0000);
        fetch_one(32'h0000_00FC);
        rand_fetch(150);

        // Reset mid-load, then a 2-word reload must mask stale words.
        pulse_load_start();
        for (int i = 0; i < 5; i++) load_word($urandom, 1'b0);
        do_reset();
        chk("rst2_count", 64'(loaded_count), 64'(0));
        chk("rst2_ready", 64'(load_ready), 64'(1));
        chk("rst2_done", 64'(load_done), 64'(0));
        load_word(32'h1111_0000, 1'b0);
        load_word(32'h1111_0001, 1'b1);
        fetch_one(32'h0000_000C);
        fetch_one(32'h0000_0004);

        // Reset coincident with a fetch request: no result may appear.
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        reset      = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        fetch_req = 1'b0;
        m_run     = 1'b0;
        m_count   = 0;
        chk("rstf_fetch_valid", 64'(fetch_valid), 64'(0));
        chk("rstf_fetch_data", 64'(fetch_data), 64'(0));
        chk("rstf_count", 64'(loaded_count), 64'(0));

`ifdef IMEM_ALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) load_word(32'h2222_0000 + 32'(i), i == 3);
        fetch_one(32'h0000_0006);
        fetch_one(32'h0000_0004);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
